// File: rtl/mesi_bus_arbiter_pkg.sv
// Shared types for the MESI snooping-bus arbiter: bus operations and arbiter FSM states.
package mesi_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_GETS = 3'd1,
    BUS_GETX = 3'd2,
    BUS_INV  = 3'd3,
    BUS_PUTX = 3'd4
  } bus_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_COLLECT,
    ST_FLUSH,
    ST_MEMRD,
    ST_MEMWR,
    ST_DONE
  } arb_state_t;

  // Values 0 and 5..7 are not real bus operations and get completed without a snoop.
  function automatic logic op_known(input logic [2:0] op);
    return (op == BUS_GETS) || (op == BUS_GETX) || (op == BUS_INV) || (op == BUS_PUTX);
  endfunction

endpackage

// File: rtl/mesi_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_CORES = 4,
  localparam int SRC_W  = $clog2(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [N_CORES-1:0] grant,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);

  always_comb begin : pick
    int cand;
    logic [SRC_W-1:0] cand_idx;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      cand     = (int'(ptr) + i) % N_CORES;
      cand_idx = cand[SRC_W-1:0];
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        idx             = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// Snooping-bus controller: round-robin grant, snoop broadcast, hit/dirty collection,
// dirty-owner writeback and memory access, then a one-cycle done to the requester.
module mesi_bus_arbiter
  import mesi_bus_arbiter_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 32,
  localparam int SRC_W  = $clog2(N_CORES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CORES-1:0]        req_valid,
  input  logic [N_CORES*3-1:0]      req_op,
  input  logic [N_CORES*ADDR_W-1:0] req_addr,
  output logic [N_CORES-1:0]        done,
  output logic                      snoop_valid,
  output logic [2:0]                snoop_op,
  output logic [ADDR_W-1:0]         snoop_addr,
  output logic [SRC_W-1:0]          snoop_src,
  input  logic [N_CORES-1:0]        snoop_hit,
  input  logic [N_CORES-1:0]        snoop_dirty,
  output logic                      share,
  output logic                      mem_rd_req,
  output logic                      mem_wr_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ack
);

  arb_state_t          state_reg, state_next;
  logic [SRC_W-1:0]    src_reg, rr_ptr_reg, gnt_idx, rr_ptr_next;
  logic [2:0]          op_reg, gnt_op;
  logic [ADDR_W-1:0]   addr_reg, gnt_addr;
  logic                share_reg, gnt_any, dirty_any;
  logic [N_CORES-1:0]  gnt_vec, own_mask;

  rr_arbiter #(.N_CORES(N_CORES)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (gnt_vec),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // One-hot of the current requester: masks its own snoop response and addresses done.
  for (genvar gi = 0; gi < N_CORES; gi++) begin : g_own
    assign own_mask[gi] = (src_reg == SRC_W'(gi));
  end

  assign dirty_any   = |(snoop_dirty & ~own_mask);
  assign rr_ptr_next = (gnt_idx == SRC_W'(N_CORES - 1)) ? '0 : gnt_idx + SRC_W'(1);
  assign share       = share_reg;

  always_comb begin
    gnt_op   = '0;
    gnt_addr = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (gnt_vec[i]) begin
        gnt_op   = req_op[i*3 +: 3];
        gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      rr_ptr_reg <= '0;
      src_reg    <= '0;
      op_reg     <= BUS_NONE;
      addr_reg   <= '0;
      share_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && gnt_any) begin
        src_reg    <= gnt_idx;
        op_reg     <= gnt_op;
        addr_reg   <= gnt_addr;
        rr_ptr_reg <= rr_ptr_next;
      end
      if (state_reg == ST_COLLECT) share_reg <= |(snoop_hit & ~own_mask);
      if (state_reg == ST_DONE)    share_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next  = state_reg;
    done        = '0;
    snoop_valid = 1'b0;
    snoop_op    = BUS_NONE;
    snoop_addr  = '0;
    snoop_src   = '0;
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
    mem_addr    = '0;
    case (state_reg)
      ST_IDLE: begin
        if (gnt_any) state_next = op_known(gnt_op) ? ST_SNOOP : ST_DONE;
      end
      ST_SNOOP: begin
        snoop_valid = 1'b1;
        snoop_op    = op_reg;
        snoop_addr  = addr_reg;
        snoop_src   = src_reg;
        state_next  = ST_COLLECT;
      end
      ST_COLLECT: begin
        case (op_reg)
          BUS_GETS, BUS_GETX: state_next = dirty_any ? ST_FLUSH : ST_MEMRD;
          BUS_PUTX:           state_next = ST_MEMWR;
          default:            state_next = ST_DONE;
        endcase
      end
      ST_FLUSH: begin
        mem_wr_req = 1'b1;
        mem_addr   = addr_reg;
        if (mem_ack) state_next = ST_MEMRD;
      end
      ST_MEMRD: begin
        mem_rd_req = 1'b1;
        mem_addr   = addr_reg;
        if (mem_ack) state_next = ST_DONE;
      end
      ST_MEMWR: begin
        mem_wr_req = 1'b1;
        mem_addr   = addr_reg;
        if (mem_ack) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = own_mask;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Directed bench for mesi_bus_arbiter (4 caches, 32-bit addresses).
module tb_mesi_bus_arbiter;
  import mesi_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [11:0] req_op;
  logic [127:0] req_addr;
  logic [3:0]  done;
  logic        snoop_valid;
  logic [2:0]  snoop_op;
  logic [31:0] snoop_addr;
  logic [1:0]  snoop_src;
  logic [3:0]  snoop_hit, snoop_dirty;
  logic        share, mem_rd_req, mem_wr_req, mem_ack;
  logic [31:0] mem_addr;

  int n_cmp = 0;
  int n_err = 0;
  int order [5] = '{0, 1, 2, 3, 0};
  int n_snp, n_done, last_done, mem_seen;

  mesi_bus_arbiter #(.N_CORES(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .done(done), .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .snoop_src(snoop_src), .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty), .share(share),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {snoop_valid, snoop_op, snoop_src, done, share, mem_rd_req, mem_wr_req}, '0);
    chk({tag, "_addr"}, {snoop_addr, mem_addr}, '0);
  endtask

  task automatic set_req(input int c, input logic [2:0] op, input logic [31:0] a);
    req_op[c*3 +: 3]     = op;
    req_addr[c*32 +: 32] = a;
    req_valid[c]         = 1'b1;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_op = '0; req_addr = '0;
    snoop_hit = '0; snoop_dirty = '0; mem_ack = 1'b0;
    tick(); tick();
    chk_quiet("reset");
    reset = 1'b0;
    tick();
    chk_quiet("idle");

    // 1: GETS cache 1, no hits, memory answers after 2 cycles
    set_req(1, BUS_GETS, 32'h40);
    tick();
    chk("t1_snoop", {snoop_valid, snoop_src, snoop_op, snoop_addr}, {1'b1, 2'd1, BUS_GETS, 32'h40});
    tick();
    chk("t1_snoop_1cyc", snoop_valid, 1'b0);
    tick();
    chk("t1_memrd", {mem_rd_req, mem_wr_req, mem_addr}, {1'b1, 1'b0, 32'h40});
    tick();
    chk("t1_memrd_hold", mem_rd_req, 1'b1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t1_done", {done, share, mem_rd_req}, {4'b0010, 1'b0, 1'b0});
    req_valid = '0;
    tick();
    chk("t1_done_pulse", done, 4'b0000);

    // 2: GETS cache 0, own hit bit masked, cache 2 hit gives share
    set_req(0, BUS_GETS, 32'h44);
    snoop_hit = 4'b0101;
    tick();
    chk("t2_src", {snoop_valid, snoop_src}, {1'b1, 2'd0});
    tick();
    tick();
    chk("t2_memrd_noflush", {mem_rd_req, mem_wr_req, share}, {1'b1, 1'b0, 1'b1});
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t2_done", {done, share}, {4'b0001, 1'b1});
    req_valid = '0; snoop_hit = '0;
    tick();
    chk("t2_share_clear", share, 1'b0);

    // 3: GETX cache 2, cache 3 dirty -> flush then read
    set_req(2, BUS_GETX, 32'h80);
    snoop_hit = 4'b1000; snoop_dirty = 4'b1000;
    tick();
    chk("t3_snoop", {snoop_src, snoop_op}, {2'd2, BUS_GETX});
    tick();
    tick();
    chk("t3_flush", {mem_wr_req, mem_rd_req, mem_addr}, {1'b1, 1'b0, 32'h80});
    mem_ack = 1'b1;
    tick();
    chk("t3_memrd", {mem_rd_req, mem_wr_req, mem_addr, done}, {1'b1, 1'b0, 32'h80, 4'b0000});
    tick();
    mem_ack = 1'b0;
    chk("t3_done", {done, share, mem_rd_req}, {4'b0100, 1'b1, 1'b0});
    req_valid = '0; snoop_hit = '0; snoop_dirty = '0;
    tick();

    // 5: PUTX cache 3 -> write only
    set_req(3, BUS_PUTX, 32'h100);
    tick();
    chk("t5_snoop", {snoop_src, snoop_op}, {2'd3, BUS_PUTX});
    tick();
    tick();
    chk("t5_memwr", {mem_wr_req, mem_rd_req, mem_addr}, {1'b1, 1'b0, 32'h100});
    tick();
    chk("t5_memwr_hold", {mem_wr_req, mem_rd_req}, {1'b1, 1'b0});
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t5_done", {done, mem_wr_req, mem_rd_req}, {4'b1000, 1'b0, 1'b0});
    req_valid = '0;
    tick();

    // 4: all caches request INV continuously -> 0,1,2,3,0 every 4 cycles
    for (int c = 0; c < 4; c++) set_req(c, BUS_INV, 32'h200 + 32'(c));
    n_snp = 0; n_done = 0; last_done = 0; mem_seen = 0;
    for (int cyc = 1; cyc <= 40 && n_done < 5; cyc++) begin
      tick();
      if (snoop_valid) begin
        if (n_snp < 5) chk("t4_grant", snoop_src, 64'(order[n_snp]));
        n_snp++;
      end
      if (done != 4'b0000) begin
        if (n_done < 5) chk("t4_done", done, 64'(1) << order[n_done]);
        if (n_done > 0) chk("t4_spacing", 64'(cyc - last_done), 64'd4);
        last_done = cyc;
        n_done++;
      end
      if (mem_rd_req || mem_wr_req) mem_seen++;
    end
    req_valid = '0;
    chk("t4_done_count", 64'(n_done), 64'd5);
    chk("t4_no_mem", 64'(mem_seen), 64'd0);
    tick();

    // Unknown op from cache 1 -> straight to done, no snoop
    set_req(1, BUS_NONE, 32'h300);
    tick();
    chk("unk_done", {done, snoop_valid}, {4'b0010, 1'b0});
    req_valid = '0;
    tick();
    chk_quiet("unk_after");

    // 6: reset during MEMRD, then rr_ptr must be back at 0
    set_req(1, BUS_GETS, 32'hC0);
    tick(); tick(); tick();
    chk("t6_memrd", mem_rd_req, 1'b1);
    reset = 1'b1; req_valid = '0;
    tick();
    chk_quiet("t6_reset");
    reset = 1'b0;
    set_req(1, BUS_INV, 32'h400);
    set_req(2, BUS_INV, 32'h500);
    tick();
    chk("t6_grant_ptr0", {snoop_valid, snoop_src}, {1'b1, 2'd1});
    tick(); tick();
    chk("t6_done1", done, 4'b0010);
    req_valid[1] = 1'b0;
    tick(); tick();
    chk("t6_grant2", {snoop_valid, snoop_src, snoop_addr}, {1'b1, 2'd2, 32'h500});
    tick(); tick();
    chk("t6_done2", done, 4'b0100);
    req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
